// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared writeback widths, requester encodings and request record
//
// Purpose: constants and types shared by the register-file write arbiter,
// its per-requester FIFO and the testbench.
//   DATA_W / ADDR_W : default write-data and register-address widths
//   REQ_A / REQ_B   : round-robin pointer encodings
//   wb_req_t        : one queued writeback {rd, data}
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small writeback request FIFO with pending-destination mask
//
// Purpose: holds queued {rd, data} writes for one requester.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (flushes the FIFO)
//   push, din      : enqueue din (ignored when full)
//   pop, dout      : dequeue the head; dout is the current head entry
//   count          : number of valid entries, 0..FIFO_DEPTH
//   full, empty    : count == FIFO_DEPTH / count == 0
//   rd_onehot_or   : OR of one-hot(rd) over all valid entries
module wb_fifo
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [ADDR_W+DATA_W-1:0]            din,
  output logic [ADDR_W+DATA_W-1:0]            dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                full,
  output logic                                empty,
  output logic [(1<<ADDR_W)-1:0]              rd_onehot_or
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Explicit wrap so depths that are not a power of two still cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (32'(count_q) == FIFO_DEPTH);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is valid when its distance from the read pointer is below count.
  always_comb begin
    rd_onehot_or = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (((i - int'(rd_ptr_q) + FIFO_DEPTH) % FIFO_DEPTH) < int'(count_q)) begin
        rd_onehot_or[mem_q[i][ENT_W-1 -: ADDR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin sharing of the register-file write port
//
// Purpose: queues writebacks from two requesters (A = pipeline WB, B = multicycle
// unit) and grants FIFO heads round-robin onto a registered write port.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   : requester A handshake and write
//   b_valid/b_ready/b_rd/b_data   : requester B handshake and write
//   rf_regWrite/rf_rd/rf_writeData: registered register-file write port
//   pending_mask                  : registers with a write queued or on the port
//   busy                          : any FIFO non-empty or a write on the port
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_rd,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_rd,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   rf_regWrite,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_writeData,
  output logic [(1<<ADDR_W)-1:0] pending_mask,
  output logic                   busy
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int NREG  = 1 << ADDR_W;

  logic [ENT_W-1:0] a_head, b_head;
  logic [CNT_W-1:0] a_count, b_count;
  logic             a_full, b_full, a_empty, b_empty;
  logic [NREG-1:0]  a_mask, b_mask, port_mask;
  logic             a_push, b_push, grant_a, grant_b;

  logic              prio_q, prio_d;
  logic              rf_regWrite_q, rf_regWrite_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_writeData_q, rf_writeData_d;

  assign a_ready = ~a_full;
  assign b_ready = ~b_full;

  // Writes to r0 complete the handshake but are never stored.
  assign a_push = a_valid & a_ready & (a_rd != '0);
  assign b_push = b_valid & b_ready & (b_rd != '0);

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo_a (
    .clk          (clk),
    .reset        (reset),
    .push         (a_push),
    .pop          (grant_a),
    .din          ({a_rd, a_data}),
    .dout         (a_head),
    .count        (a_count),
    .full         (a_full),
    .empty        (a_empty),
    .rd_onehot_or (a_mask)
  );

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo_b (
    .clk          (clk),
    .reset        (reset),
    .push         (b_push),
    .pop          (grant_b),
    .din          ({b_rd, b_data}),
    .dout         (b_head),
    .count        (b_count),
    .full         (b_full),
    .empty        (b_empty),
    .rd_onehot_or (b_mask)
  );

  always_comb begin
    grant_a        = ~a_empty & (b_empty | (prio_q == REQ_A));
    grant_b        = ~b_empty & (a_empty | (prio_q == REQ_B));
    prio_d         = prio_q;
    rf_regWrite_d  = grant_a | grant_b;
    rf_rd_d        = rf_rd_q;
    rf_writeData_d = rf_writeData_q;
    if (grant_a) begin
      prio_d         = REQ_B;
      rf_rd_d        = a_head[ENT_W-1 -: ADDR_W];
      rf_writeData_d = a_head[DATA_W-1:0];
    end else if (grant_b) begin
      prio_d         = REQ_A;
      rf_rd_d        = b_head[ENT_W-1 -: ADDR_W];
      rf_writeData_d = b_head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q         <= REQ_A;
      rf_regWrite_q  <= 1'b0;
      rf_rd_q        <= '0;
      rf_writeData_q <= '0;
    end else begin
      prio_q         <= prio_d;
      rf_regWrite_q  <= rf_regWrite_d;
      rf_rd_q        <= rf_rd_d;
      rf_writeData_q <= rf_writeData_d;
    end
  end

  always_comb begin
    port_mask = '0;
    if (rf_regWrite_q) port_mask[rf_rd_q] = 1'b1;
  end

  assign rf_regWrite  = rf_regWrite_q;
  assign rf_rd        = rf_rd_q;
  assign rf_writeData = rf_writeData_q;
  assign pending_mask = a_mask | b_mask | port_mask;
  assign busy         = (a_count != '0) | (b_count != '0) | rf_regWrite_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_regWrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_writeData;
  logic [31:0] pending_mask;
  logic        busy;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .rf_regWrite  (rf_regWrite),
    .rf_rd        (rf_rd),
    .rf_writeData (rf_writeData),
    .pending_mask (pending_mask),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Reference model: two request queues, a port record and a "B goes next" flag.
  wb_req_t     qa[$];
  wb_req_t     qb[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_b_next;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [31:0] exp_mask;
    exp_mask = '0;
    foreach (qa[i]) exp_mask[qa[i].rd] = 1'b1;
    foreach (qb[i]) exp_mask[qb[i].rd] = 1'b1;
    if (m_we) exp_mask[m_rd] = 1'b1;
    chk("a_ready", 64'(a_ready), 64'(qa.size() != DEPTH));
    chk("b_ready", 64'(b_ready), 64'(qb.size() != DEPTH));
    chk("rf_regWrite", 64'(rf_regWrite), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_writeData", 64'(rf_writeData), 64'(m_data));
    chk("pending_mask", 64'(pending_mask), 64'(exp_mask));
    chk("busy", 64'(busy), 64'(qa.size() != 0 || qb.size() != 0 || m_we));
  endtask

  task automatic model_edge(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    int na, nb;
    wb_req_t e;
    if (r) begin
      qa.delete(); qb.delete();
      m_we = 0; m_rd = '0; m_data = '0; m_b_next = 0;
      return;
    end
    na = qa.size();
    nb = qb.size();
    if (na > 0 && (nb == 0 || !m_b_next)) begin
      e = qa.pop_front();
      m_we = 1; m_rd = e.rd; m_data = e.data; m_b_next = 1;
    end else if (nb > 0) begin
      e = qb.pop_front();
      m_we = 1; m_rd = e.rd; m_data = e.data; m_b_next = 0;
    end else begin
      m_we = 0;
    end
    if (av && na != DEPTH && ard != 0) qa.push_back('{rd: ard, data: ad});
    if (bv && nb != DEPTH && brd != 0) qb.push_back('{rd: brd, data: bd});
  endtask

  // Check the state left by the previous edge, then drive the next edge's inputs.
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    @(negedge clk);
    if (chk_en) check_outputs();
    reset = r; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    model_edge(r, av, ard, ad, bv, brd, bd);
  endtask

  task automatic idle();
    step(0, 0, $urandom_range(0, 31), $urandom, 0, $urandom_range(0, 31), $urandom);
  endtask

  task automatic do_reset();
    step(1, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk_en = 1;

    // Single write from A
    step(0, 1, 5'd5, 32'h1234, 0, '0, '0);
    idle();
    idle();
    chk("t1_we", 64'(rf_regWrite), 64'd1);
    chk("t1_rd", 64'(rf_rd), 64'd5);
    chk("t1_data", 64'(rf_writeData), 64'h1234);
    repeat (3) idle();

    // Simultaneous requests with the pointer at A
    do_reset();
    step(0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    idle();
    idle();
    chk("t2_first_rd", 64'(rf_rd), 64'd3);
    idle();
    chk("t2_second_rd", 64'(rf_rd), 64'd4);
    idle();
    chk("t2_idle_we", 64'(rf_regWrite), 64'd0);

    // Saturation with distinct destinations
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 5'(1 + (i % 15)), $urandom, 1, 5'(16 + (i % 15)), $urandom);
    end
    repeat (6) idle();

    // r0 write is accepted and dropped
    do_reset();
    step(0, 1, 5'd0, 32'hFFFF, 0, '0, '0);
    idle();
    idle();
    chk("t4_we", 64'(rf_regWrite), 64'd0);
    chk("t4_mask", 64'(pending_mask), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);

    // Backpressure on B while A streams
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 5'(1 + i), $urandom, 1, 5'(20 + (i % 3)), $urandom);
    end
    repeat (6) idle();

    // Reset while both queues hold writes and the port is active
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5'(6 + i), $urandom, 1, 5'(12 + i), $urandom);
    end
    idle();
    chk("t6_busy_before", 64'(busy), 64'd1);
    do_reset();
    idle();
    chk("t6_we_after", 64'(rf_regWrite), 64'd0);
    chk("t6_mask_after", 64'(pending_mask), 64'd0);
    step(0, 1, 5'd7, 32'h77, 1, 5'd9, 32'h99);
    idle();
    idle();
    chk("t6_a_first", 64'(rf_rd), 64'd7);
    repeat (3) idle();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (6) idle();

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
